// File: rtl/gerador_tom_cp.sv
// Square-wave tone generator: plays a period of cp clock cycles while gate is held
// and always finishes the current period before going silent.
module gerador_tom_cp #(
  parameter int LARGURA_CP = 18,
  parameter int CP_MIN     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LARGURA_CP-1:0] cp,
  input  logic                  gate,
  output logic                  onda,
  output logic                  ativo,
  output logic                  fim_periodo
);

  typedef enum logic [1:0] {IDLE, TOCANDO, PARANDO} estado_t;

  localparam logic [LARGURA_CP-1:0] CP_MIN_L = LARGURA_CP'(CP_MIN);
  localparam logic [LARGURA_CP-1:0] UM       = LARGURA_CP'(1);
  localparam logic [LARGURA_CP-1:0] ZERO     = '0;

  estado_t               estado_q, estado_d;
  logic [LARGURA_CP-1:0] cnt_q, cnt_d;
  logic [LARGURA_CP-1:0] cp_lat_q, cp_lat_d;
  logic                  onda_q, onda_d;
  logic [LARGURA_CP-1:0] cpEfetivo;
  logic [LARGURA_CP-1:0] cntMais1;
  logic                  ultimo;

  assign cpEfetivo = (cp < CP_MIN_L) ? CP_MIN_L : cp;
  assign cntMais1  = cnt_q + UM;
  assign ultimo    = (estado_q != IDLE) && (cnt_q == (cp_lat_q - UM));

  // The tone only continues past a wrap if the key was held on either side of the
  // period boundary; the period is resampled there and nowhere else.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cp_lat_d = cp_lat_q;
    onda_d   = onda_q;
    case (estado_q)
      IDLE: begin
        cnt_d  = ZERO;
        onda_d = 1'b0;
        if (gate) begin
          cp_lat_d = cpEfetivo;
          onda_d   = 1'b1;
          estado_d = TOCANDO;
        end
      end
      TOCANDO, PARANDO: begin
        if (ultimo) begin
          cnt_d = ZERO;
          if ((estado_q == TOCANDO) || gate) begin
            cp_lat_d = cpEfetivo;
            onda_d   = 1'b1;
            estado_d = gate ? TOCANDO : PARANDO;
          end else begin
            onda_d   = 1'b0;
            estado_d = IDLE;
          end
        end else begin
          cnt_d    = cntMais1;
          onda_d   = cntMais1 < (cp_lat_q >> 1);
          estado_d = gate ? TOCANDO : PARANDO;
        end
      end
      default: begin
        cnt_d    = ZERO;
        onda_d   = 1'b0;
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= IDLE;
      cnt_q    <= ZERO;
      cp_lat_q <= CP_MIN_L;
      onda_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cp_lat_q <= cp_lat_d;
      onda_q   <= onda_d;
    end
  end

  assign onda        = onda_q;
  assign ativo       = (estado_q != IDLE);
  assign fim_periodo = ultimo;

endmodule

// File: tb/tb_gerador_tom_cp.sv
// Self-checking bench for gerador_tom_cp: directed scenarios plus random key/period
// activity, all compared against a period-position model of the tone.
module tb_gerador_tom_cp;

  localparam int LARGURA_CP = 18;
  localparam int CP_MIN     = 4;

  logic                  clk;
  logic                  rst_n;
  logic [LARGURA_CP-1:0] cp;
  logic                  gate;
  logic                  onda;
  logic                  ativo;
  logic                  fim_periodo;

  int checks;
  int errors;

  // Model: whether a tone sounds, its period, position inside it, and the last gate seen.
  bit sounding;
  bit lastGate;
  int per;
  int pos;
  logic [2:0] expVec;

  gerador_tom_cp #(.LARGURA_CP(LARGURA_CP), .CP_MIN(CP_MIN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cp          (cp),
    .gate        (gate),
    .onda        (onda),
    .ativo       (ativo),
    .fim_periodo (fim_periodo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampCp(input int c);
    return (c < CP_MIN) ? CP_MIN : c;
  endfunction

  function automatic logic [2:0] expected();
    logic eo, ea, ef;
    ea = sounding;
    eo = sounding && (pos < per / 2);
    ef = sounding && (pos == per - 1);
    return {eo, ea, ef};
  endfunction

  task automatic modelReset();
    sounding = 1'b0;
    pos      = 0;
    per      = CP_MIN;
    lastGate = 1'b0;
  endtask

  // One rising edge: move the model on with the inputs the DUT sampled, then settle.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      modelReset();
    end else if (!sounding) begin
      if (gate) begin
        sounding = 1'b1;
        per      = clampCp(int'(cp));
        pos      = 0;
        lastGate = 1'b1;
      end
    end else begin
      if (pos == per - 1) begin
        if (lastGate || gate) begin
          per = clampCp(int'(cp));
          pos = 0;
        end else begin
          sounding = 1'b0;
          pos      = 0;
        end
      end else begin
        pos++;
      end
      lastGate = gate;
    end
    #1;
    expVec = expected();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gate  = 1'b1;
    cp    = 18'd10;
    modelReset();
    #1;
    checks++;
    if ({onda, ativo, fim_periodo} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_async got=%b want=000", {onda, ativo, fim_periodo});
    end
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if ({onda, ativo, fim_periodo} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_held cyc=%0d got=%b want=000", i, {onda, ativo, fim_periodo});
      end
    end
    gate  = 1'b0;
    rst_n = 1'b1;
    advance();
    checks++;
    if ({onda, ativo, fim_periodo} !== expVec) begin
      errors++;
      $display("[TB] FAIL reset_release got=%b want=%b", {onda, ativo, fim_periodo}, expVec);
    end
  endtask

  task automatic test_basic();
    int highs;
    highs = 0;
    cp    = 18'd10;
    gate  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      advance();
      checks++;
      if ({onda, ativo, fim_periodo} !== expVec) begin
        errors++;
        $display("[TB] FAIL basic_cp10 cyc=%0d got=%b want=%b", i, {onda, ativo, fim_periodo}, expVec);
      end
      if (i >= 10 && i < 20 && onda === 1'b1) highs++;
    end
    checks++;
    if (highs !== 5) begin
      errors++;
      $display("[TB] FAIL basic_high_count got=%0d want=5", highs);
    end
  endtask

  task automatic test_clamp();
    int values[3] = '{7, 0, 3};
    foreach (values[k]) begin
      cp = 18'(values[k]);
      for (int i = 0; i < 24; i++) begin
        advance();
        checks++;
        if ({onda, ativo, fim_periodo} !== expVec) begin
          errors++;
          $display("[TB] FAIL clamp_cp%0d cyc=%0d got=%b want=%b", values[k], i,
                   {onda, ativo, fim_periodo}, expVec);
        end
      end
    end
  endtask

  task automatic test_cp_change();
    cp = 18'd10;
    for (int i = 0; i < 40 && !(sounding && per == 10 && pos == 2); i++) advance();
    checks++;
    if (!(sounding && per == 10 && pos == 2)) begin
      errors++;
      $display("[TB] FAIL cp_change_sync timeout pos=%0d per=%0d", pos, per);
    end
    cp = 18'd6;
    for (int i = 0; i < 20; i++) begin
      advance();
      checks++;
      if ({onda, ativo, fim_periodo} !== expVec) begin
        errors++;
        $display("[TB] FAIL cp_change cyc=%0d got=%b want=%b", i, {onda, ativo, fim_periodo}, expVec);
      end
    end
  endtask

  task automatic test_release();
    int relAt[2] = '{1, 7};
    foreach (relAt[k]) begin
      cp   = 18'd10;
      gate = 1'b1;
      for (int i = 0; i < 40 && !(sounding && per == 10 && pos == 1); i++) advance();
      gate = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (k == 1 && sounding && pos == relAt[k]) gate = 1'b1;
        advance();
        checks++;
        if ({onda, ativo, fim_periodo} !== expVec) begin
          errors++;
          $display("[TB] FAIL release_case%0d cyc=%0d got=%b want=%b", k, i,
                   {onda, ativo, fim_periodo}, expVec);
        end
      end
    end
    gate = 1'b0;
    for (int i = 0; i < 12; i++) advance();
  endtask

  task automatic test_reset_mid();
    cp   = 18'd10;
    gate = 1'b1;
    for (int i = 0; i < 40 && !(sounding && pos == 3); i++) advance();
    #2;
    rst_n = 1'b0;
    gate  = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({onda, ativo, fim_periodo} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_mid_async got=%b want=000", {onda, ativo, fim_periodo});
    end
    #1;
    rst_n = 1'b1;
    gate  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      advance();
      checks++;
      if ({onda, ativo, fim_periodo} !== expVec) begin
        errors++;
        $display("[TB] FAIL reset_mid_restart cyc=%0d got=%b want=%b", i, {onda, ativo, fim_periodo}, expVec);
      end
    end
  endtask

  task automatic test_long_period();
    gate = 1'b0;
    for (int i = 0; i < 12; i++) advance();
    cp   = 18'd143172;
    gate = 1'b1;
    for (int i = 0; i < 300; i++) begin
      advance();
      checks++;
      if ({onda, ativo, fim_periodo} !== expVec) begin
        errors++;
        $display("[TB] FAIL long_period cyc=%0d got=%b want=%b", i, {onda, ativo, fim_periodo}, expVec);
      end
    end
    gate = 1'b0;
    cp   = 18'd5;
    for (int i = 0; i < 200 && sounding; i++) advance();
  endtask

  task automatic test_random();
    gate = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      if ($urandom_range(0, 24) == 0) cp = 18'($urandom_range(0, 16));
      advance();
      checks++;
      if ({onda, ativo, fim_periodo} !== expVec) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d cp=%0d gate=%b got=%b want=%b", i, cp, gate,
                 {onda, ativo, fim_periodo}, expVec);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_clamp();
    test_cp_change();
    test_release();
    test_reset_mid();
    test_long_period();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gerador_tom_cp.md
GERADOR_TOM_CP -- requirements
Module: gerador_tom_cp

Interface
REQ-001: Parameter LARGURA_CP, default 18, SHALL set the width of cp and of the internal period counter.
REQ-002: Parameter CP_MIN, default 4, SHALL set the smallest period in clock cycles that the block accepts.
REQ-003: clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004: rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005: cp  input  LARGURA_CP  SHALL be the full tone period in clk cycles, as produced by the key-to-period mapping (e.g. 143172 = F4 at 50 MHz).
REQ-006: gate  input  1  SHALL request the tone: 1 = key held, 0 = key released.
REQ-007: onda  output  1  SHALL be the registered square-wave audio output.
REQ-008: ativo  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-009: fim_periodo  output  1  SHALL be a one-cycle pulse marking the last cycle of each generated period.

Function
REQ-010: The FSM SHALL have exactly three states: IDLE, TOCANDO, PARANDO.
REQ-011: The effective period P SHALL be max(cp, CP_MIN), sampled into an internal register cp_lat.
REQ-012: Within a period, onda SHALL be high for H = P>>1 cycles, then low for L = P - H cycles; for odd P the low phase is one cycle longer.
REQ-013: In IDLE, onda=0, fim_periodo=0, and the counter SHALL hold 0.
REQ-014: In IDLE, a rising clock edge with gate=1 SHALL latch cp_lat, clear the counter, set onda=1, and enter TOCANDO; onda rises one cycle after gate is first sampled high.
REQ-015: In TOCANDO/PARANDO, the counter SHALL increment by 1 each cycle from 0 to P-1, then wrap to 0.
REQ-016: fim_periodo SHALL be 1 exactly in the cycle where the counter equals P-1, and 0 otherwise.
REQ-017: At each wrap in TOCANDO, cp SHALL be resampled into cp_lat; changes on cp at any other time SHALL NOT affect the period in progress.
REQ-018: In TOCANDO, gate=0 SHALL move the FSM to PARANDO without altering onda or the counter.
REQ-019: In PARANDO, the current period SHALL complete; at the wrap the FSM SHALL enter IDLE with onda=0.
REQ-020: In PARANDO, gate=1 SHALL return the FSM to TOCANDO with no gap or phase change in onda.
REQ-021: If gate falls and cp changes in the same cycle, the gate rule SHALL apply, and the new cp SHALL be ignored unless the period continues past a wrap in TOCANDO.
REQ-022: Entering IDLE and having gate=1 in that same wrap cycle SHALL NOT occur; PARANDO with gate=1 goes to TOCANDO per REQ-020.
REQ-023: The counter SHALL never exceed P-1 and SHALL never overflow LARGURA_CP bits.

Reset
REQ-024: While rst_n=0, the block SHALL be in IDLE with onda=0, ativo=0, fim_periodo=0, counter=0 and cp_lat=CP_MIN, independent of clk.
REQ-025: Assertion of rst_n mid-tone SHALL silence onda immediately and asynchronously.
REQ-026: After rst_n is released, a new tone SHALL start only via REQ-014.

Verification
REQ-027: cp=10, gate held -> onda 5 high / 5 low repeating; fim_periodo pulses every 10 cycles on the last low cycle; ativo=1.
REQ-028: cp=7 -> onda 3 high / 4 low; cp=0 or 3 -> clamped to P=4, 2 high / 2 low.
REQ-029: cp=10 playing, cp changed to 6 at counter=2 -> current period stays 10 cycles; the next period is 3 high / 3 low.
REQ-030: cp=10, gate dropped at counter=1 -> period finishes (5 high / 5 low); IDLE after the fim_periodo cycle, ativo=0; gate re-raised at counter=7 instead -> continuous output, ativo stays 1.
REQ-031: cp=143172 -> 71586 high / 71586 low, with no counter overflow.
REQ-032: rst_n pulsed low at counter=3 of a cp=10 tone -> onda=0 and ativo=0 immediately; gate=1 after release -> onda rises one cycle later with a fresh period.
